// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    // Counters must be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Redirect, instruction-memory and decode channels of the fetch queue.
interface ifetch_queue_if
    import ifetch_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;

    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;

    logic             dec_valid;
    logic             dec_ready;
    logic [WIDTH-1:0] dec_instr;
    logic [WIDTH-1:0] dec_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Small first-word-fall-through FIFO of fetch entries with flush.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = cnt_width(DEPTH),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: sequential PC, credit-limited imem requests, response queue to decode.
// Define IFETCH_QUEUE_BYPASS_EN for a zero-cycle response-to-decode bypass when the queue is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    ifetch_queue_if.master bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 2;
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] rsp_pc;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop_cnt;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    entry_t           fifo_head;
    entry_t           push_entry;

    logic [SW-1:0]    outstanding;
    logic             req_fire;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             bypass_active;
    logic             dec_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] redirect_target;

    // Everything queued, in flight or still owed a drop holds one credit.
    assign outstanding = SW'(fifo_count) + SW'(inflight) + SW'(drop_cnt);

    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (outstanding < SW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_drop        = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep        = bus.imem_rsp_valid && (drop_cnt == '0);
    assign redirect_target = bus.redirect_pc & ALIGN_MASK;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass_active = rsp_keep && fifo_empty && !bus.redirect_valid;
`else
    assign bypass_active = 1'b0;
`endif

    assign bus.dec_valid = !fifo_empty || bypass_active;
    assign bus.dec_instr = bypass_active ? bus.imem_rsp_data : fifo_head.instr;
    assign bus.dec_pc    = bypass_active ? rsp_pc : fifo_head.pc;
    assign dec_fire      = bus.dec_valid && bus.dec_ready;

    // A bypassed response taken by decode never touches the queue.
    assign fifo_push  = rsp_keep && !bus.redirect_valid && !(bypass_active && bus.dec_ready);
    assign fifo_pop   = dec_fire && !fifo_empty;
    assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (bus.redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Redirect turns every still-unanswered request into a pending drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
            inflight <= '0;
            drop_cnt <= drop_cnt + inflight - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + STEP;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> ((SW'(inflight) + SW'(drop_cnt)) != '0));

    no_queue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if #(.WIDTH(32)) bus ();

    ifetch_queue #(
        .WIDTH    (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];
    ent_t        q[$];
    logic [31:0] dec_log[$];
    logic [31:0] exp_fetch;
    int          epoch, cyc, tests, fails, accepts;
    int          rdy_pct, drdy_pct, lat_lo, lat_hi;
    bit          cap_en, lat_track;
    int          first_rsp, first_dec;

    // Memory content: an odd multiply makes every address hold a distinct word.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit redir, input logic [31:0] target);
        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        bus.imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        bus.dec_ready      = (int'($urandom_range(99)) < drdy_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(pend[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
    endtask

    task automatic checkOutput();
        logic        exp_rv, rsp_cur, byp, exp_dv;
        logic [31:0] exp_pc, exp_instr;
        req_t        r;
        @(negedge clk);
        exp_rv = !bus.redirect_valid && ((pend.size() + q.size()) < DEPTH);
        checkEq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        checkEq("req_addr", bus.imem_req_addr, exp_fetch);
        rsp_cur = bus.imem_rsp_valid && (pend.size() > 0) && (pend[0].epoch == epoch);
        byp     = BYPASS && rsp_cur && (q.size() == 0) && !bus.redirect_valid;
        exp_dv  = (q.size() > 0) || byp;
        checkEq("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
        if (exp_dv) begin
            exp_pc    = (q.size() > 0) ? q[0].pc : pend[0].addr;
            exp_instr = (q.size() > 0) ? q[0].instr : memf(pend[0].addr);
            checkEq("dec_pc", bus.dec_pc, exp_pc);
            checkEq("dec_instr", bus.dec_instr, exp_instr);
        end
        if (lat_track) begin
            if (bus.imem_rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (bus.dec_valid && first_dec < 0) first_dec = cyc;
        end
        if (cap_en && bus.dec_valid && bus.dec_ready) dec_log.push_back(bus.dec_pc);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            accepts++;
            pend.push_back('{addr: bus.imem_req_addr, epoch: epoch,
                             due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (exp_dv && bus.dec_ready && q.size() > 0) void'(q.pop_front());
        if (bus.imem_rsp_valid && pend.size() > 0) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !bus.redirect_valid && !(byp && bus.dec_ready))
                q.push_back('{pc: r.addr, instr: memf(r.addr)});
        end
        if (bus.redirect_valid) begin
            q.delete();
            epoch++;
            exp_fetch = bus.redirect_pc & ~32'd3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runCycles(input int n, input bit allow_redir);
        for (int i = 0; i < n; i++) begin
            if (allow_redir && int'($urandom_range(99)) < 4)
                applyStimulus(1'b1, $urandom());
            else
                applyStimulus(1'b0, 32'h0);
            checkOutput();
        end
    endtask

    // Memory shares the reset, so all outstanding model state is discarded too.
    task automatic resetDut();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dec_ready      = 1'b0;
        #2;
        checkEq("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkEq("rst_req_addr", bus.imem_req_addr, 32'h0);
        checkEq("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        checkEq("rst_dec_instr", bus.dec_instr, 32'h0);
        checkEq("rst_dec_pc", bus.dec_pc, 32'h0);
        pend.delete();
        q.delete();
        epoch     = 0;
        exp_fetch = 32'h0;
        accepts   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    function automatic logic [31:0] logAt(input int i);
        return (dec_log.size() > i) ? dec_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bit found;
        tests = 0; fails = 0; cyc = 0; epoch = 0;
        cap_en = 0; lat_track = 0; first_rsp = -1; first_dec = -1;
        rdy_pct = 100; drdy_pct = 100; lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        #1;

        $display("[TB] sequential fetch, 1-cycle memory");
        resetDut();
        dec_log.delete(); cap_en = 1;
        runCycles(20, 1'b0);
        cap_en = 0;
        checkEq("seq_pc0", logAt(0), 32'h0);
        checkEq("seq_pc1", logAt(1), 32'h4);
        checkEq("seq_pc2", logAt(2), 32'h8);

        $display("[TB] decode stalled, credit limit");
        resetDut();
        drdy_pct = 0;
        runCycles(10, 1'b0);
        checkEq("fill_accepts", 32'(accepts), 32'd4);
        checkEq("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkEq("resume_addr", bus.imem_req_addr, 32'h10);
        drdy_pct = 100;
        dec_log.delete(); cap_en = 1;
        runCycles(10, 1'b0);
        cap_en = 0;
        checkEq("drain_pc0", logAt(0), 32'h0);
        checkEq("drain_pc3", logAt(3), 32'hC);
        checkEq("drain_pc4", logAt(4), 32'h10);

        $display("[TB] redirect with two requests in flight");
        resetDut();
        lat_lo = 3; lat_hi = 3;
        for (int g = 0; g < 10 && pend.size() < 2; g++) runCycles(1, 1'b0);
        checkEq("d_inflight", 32'(pend.size()), 32'd2);
        applyStimulus(1'b1, 32'h0000_0103);
        checkOutput();
        checkEq("d_next_addr", bus.imem_req_addr, 32'h100);
        dec_log.delete(); cap_en = 1;
        runCycles(15, 1'b0);
        cap_en = 0;
        checkEq("d_first_dec_pc", logAt(0), 32'h100);
        checkEq("d_second_dec_pc", logAt(1), 32'h104);

        $display("[TB] redirect with response and decode handshake");
        resetDut();
        lat_lo = 1; lat_hi = 1; drdy_pct = 0;
        runCycles(5, 1'b0);
        drdy_pct = 100;
        found = 0;
        for (int g = 0; g < 20 && !found; g++) begin
            if (pend.size() > 0 && pend[0].due <= cyc && q.size() > 0) begin
                found = 1;
                applyStimulus(1'b1, 32'h0000_2000);
            end else begin
                applyStimulus(1'b0, 32'h0);
            end
            checkOutput();
        end
        checkEq("e_collision_found", 32'(found), 32'h1);
        dec_log.delete(); cap_en = 1;
        runCycles(12, 1'b0);
        cap_en = 0;
        checkEq("e_first_dec_pc", logAt(0), 32'h2000);
        checkEq("e_second_dec_pc", logAt(1), 32'h2004);

        $display("[TB] address wrap");
        resetDut();
        applyStimulus(1'b1, 32'hFFFF_FFF0);
        checkOutput();
        dec_log.delete(); cap_en = 1;
        runCycles(12, 1'b0);
        cap_en = 0;
        checkEq("wrap_pc3", logAt(3), 32'hFFFF_FFFC);
        checkEq("wrap_pc4", logAt(4), 32'h0000_0000);
        checkEq("wrap_pc5", logAt(5), 32'h0000_0004);

        $display("[TB] fetch-to-decode latency");
        resetDut();
        first_rsp = -1; first_dec = -1; lat_track = 1;
        runCycles(6, 1'b0);
        lat_track = 0;
        checkEq("rsp_to_dec_latency", 32'(first_dec - first_rsp), BYPASS ? 32'd0 : 32'd1);

        $display("[TB] randomized traffic with mid-run resets");
        for (int round = 0; round < 5; round++) begin
            rdy_pct  = int'($urandom_range(100, 30));
            drdy_pct = int'($urandom_range(100, 20));
            lat_lo   = 1;
            lat_hi   = int'($urandom_range(4, 1));
            runCycles(150, 1'b1);
            resetDut();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
